// File: rtl/pixel_link_pkg.sv
// Shared definitions for the pixel row link: row width, counter sizing and the row word type.
package pixel_link_pkg;

  localparam int ROW_WIDTH = 128;

  // Counter width for a row of w bits; rows are at least 2 bits so this is never 0.
  function automatic int cnt_width(input int w);
    return $clog2(w);
  endfunction

  typedef logic [ROW_WIDTH-1:0] row_word_t;

endpackage

// File: rtl/pixel_row_holdbuf.sv
// One-entry valid/ready holding register; flags a sticky overrun when a load finds it full and not draining.
module pixel_row_holdbuf
  import pixel_link_pkg::*;
#(
  parameter int WIDTH = ROW_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_overrun
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_overrun;
  logic             w_take;

  assign w_take = r_valid && i_ready;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else if (i_load) begin
      // A load lands if the slot is empty or is being drained this same cycle.
      if (!r_valid || w_take) begin
        r_data  <= i_data;
        r_valid <= 1'b1;
      end else begin
        r_overrun <= 1'b1;
      end
    end else if (w_take) begin
      r_valid <= 1'b0;
    end
  end

  assign o_data    = r_data;
  assign o_valid   = r_valid;
  assign o_overrun = r_overrun;

endmodule

// File: rtl/pixel_row_deserializer.sv
// Receive end of the pixel row link: shifts serial bits MSB first into a row word and hands it off.
module pixel_row_deserializer
  import pixel_link_pkg::*;
#(
  parameter int WIDTH = ROW_WIDTH,
  localparam int CNT_W = cnt_width(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             row_start,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             overrun,
  output logic [CNT_W-1:0] bit_count
);

  logic [WIDTH-1:0] r_shreg;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] w_next_row;
  logic             w_last;

  assign w_next_row = {r_shreg[WIDTH-2:0], bit_in};
  // row_start restarts the count, so a bit taken with it can never be the last one.
  assign w_last     = bit_valid && !row_start && (r_count == CNT_W'(WIDTH - 1));

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_shreg <= '0;
      r_count <= '0;
    end else if (row_start) begin
      r_count <= bit_valid ? CNT_W'(1) : '0;
      if (bit_valid) r_shreg <= w_next_row;
    end else if (bit_valid) begin
      r_shreg <= w_next_row;
      r_count <= w_last ? '0 : r_count + CNT_W'(1);
    end
  end

  pixel_row_holdbuf #(
    .WIDTH(WIDTH)
  ) u_holdbuf (
    .clock    (clock),
    .reset    (reset),
    .i_load   (w_last),
    .i_data   (w_next_row),
    .i_ready  (word_ready),
    .o_data   (word_out),
    .o_valid  (word_valid),
    .o_overrun(overrun)
  );

  assign bit_count = r_count;

endmodule
